// File: rtl/gpr_ctrl_pkg.sv
// Shared widths and the register-file write record used by the GPR write-port arbiter.
// Pure declarations: no logic, no latency, no flow control.
package gpr_ctrl_pkg;
  localparam int XLEN   = 32;
  localparam int REG_AW = 5;
  localparam int NREGS  = 32;

  typedef struct packed {
    logic [REG_AW-1:0] ws;
    logic [XLEN-1:0]   wd;
  } gpr_wr_t;
endpackage

// File: rtl/ll_result_fifo.sv
// Buffer for long-latency results awaiting the write port; head visible combinationally, 1-cycle push-to-pop.
// Push is ignored when full and pop when empty; the caller gates push with ~full.
module ll_result_fifo
  import gpr_ctrl_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic    clk,
  input  logic    rst,
  input  logic    push,
  input  logic    pop,
  input  gpr_wr_t din,
  output gpr_wr_t dout,
  output logic    full,
  output logic    empty
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  gpr_wr_t        mem [DEPTH];
  logic [AW-1:0]  wr_ptr;
  logic [AW-1:0]  rd_ptr;
  logic [AW:0]    count;
  logic           do_push;
  logic           do_pop;

  function automatic logic [AW-1:0] ptr_next(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= ptr_next(wr_ptr);
      if (do_pop)  rd_ptr <= ptr_next(rd_ptr);
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

  // Storage needs no reset: entries are only observed once count says they are valid.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end
endmodule

// File: rtl/gpr_wb_arbiter.sv
// Shares the GPR write port between pipeline writeback (0-cycle, always wins) and buffered LL results (>=1 cycle).
// LL side backpressured by ll_ready = ~full; decode stalled on busy-register hazards or LL starvation.
module gpr_wb_arbiter
  import gpr_ctrl_pkg::*;
#(
  parameter int FIFO_DEPTH   = 2,
  parameter int STARVE_LIMIT = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic              id_use_rs1,
  input  logic              id_use_rs2,
  input  logic [REG_AW-1:0] id_ws,
  input  logic              id_ll,
  output logic              stall,
  input  logic              wb_valid,
  input  logic [REG_AW-1:0] wb_ws,
  input  logic [XLEN-1:0]   wb_wd,
  input  logic              ll_valid,
  output logic              ll_ready,
  input  logic [REG_AW-1:0] ll_ws,
  input  logic [XLEN-1:0]   ll_wd,
  output logic              RegWrite,
  output logic [REG_AW-1:0] ws,
  output logic [XLEN-1:0]   wd
);
  localparam int CW = $clog2(STARVE_LIMIT + 1);

  gpr_wr_t          head;
  gpr_wr_t          ll_in;
  logic             full;
  logic             empty;
  logic             push;
  logic             drain;
  logic             hazard;
  logic             starve;
  logic             issue;
  logic [NREGS-1:0] busy;
  logic [CW-1:0]    wait_cnt;

  assign ll_ready = ~full;
  // Results for x0 are acknowledged but never buffered, so the FIFO only ever holds real writes.
  assign push     = ll_valid & ~full & (ll_ws != '0);
  assign drain    = ~wb_valid & ~empty;
  assign ll_in    = {ll_ws, ll_wd};

  ll_result_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (drain),
    .din   (ll_in),
    .dout  (head),
    .full  (full),
    .empty (empty)
  );

  always_comb begin
    RegWrite = 1'b0;
    ws       = '0;
    wd       = '0;
    if (wb_valid) begin
      RegWrite = (wb_ws != '0);
      ws       = wb_ws;
      wd       = wb_wd;
    end else if (!empty) begin
      RegWrite = 1'b1;
      ws       = head.ws;
      wd       = head.wd;
    end
  end

  assign hazard = id_valid & ((id_use_rs1 & busy[id_rs1]) |
                              (id_use_rs2 & busy[id_rs2]) |
                              ((id_ws != '0) & busy[id_ws]));
  assign starve = (wait_cnt == CW'(STARVE_LIMIT));
  assign stall  = hazard | starve;
  assign issue  = id_valid & ~stall;

  // The set is written last so it overrides a same-cycle clear of the same register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy <= '0;
    end else begin
      if (drain) busy[head.ws] <= 1'b0;
      if (issue && id_ll && (id_ws != '0)) busy[id_ws] <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wait_cnt <= '0;
    end else if (empty || drain) begin
      wait_cnt <= '0;
    end else if (!starve) begin
      wait_cnt <= wait_cnt + 1'b1;
    end
  end
endmodule
